// File: rtl/axis_spi_tx.sv
// AXI-Stream sink feeding a mode-0 SPI master transmitter, MSB first.
// csn_o frames a packet from its first non-null beat until after the tlast beat.
module axis_spi_tx #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned CS_IDLE_CYC = 2
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [DATA_W-1:0]   tdata_i,
    input  logic [DATA_W/8-1:0] tkeep_i,
    input  logic                tlast_i,
    input  logic                tvalid_i,
    output logic                tready_o,
    output logic                sck_o,
    output logic                mosi_o,
    output logic                csn_o,
    output logic                busy_o
);

    localparam int unsigned MAX_CNT = (CLK_DIV > CS_IDLE_CYC) ? CLK_DIV : CS_IDLE_CYC;
    localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int unsigned BIT_W   = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_IDLE_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, SHIFT, WAIT, HOLD, GAP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                last_q, last_d;
    logic                rdy_q;
    logic                sck_q, sck_d;
    logic                mosi_q, mosi_d;
    logic                csn_q, csn_d;
    logic                hs;
    logic                beat;

    assign tready_o = rdy_q && (state_q == IDLE || state_q == WAIT);
    assign hs       = tvalid_i && tready_o;
    assign beat     = |tkeep_i;

    assign sck_o  = sck_q;
    assign mosi_o = mosi_q;
    assign csn_o  = csn_q;
    assign busy_o = (state_q != IDLE);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            last_q  <= 1'b0;
            rdy_q   <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            csn_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            last_q  <= last_d;
            rdy_q   <= 1'b1;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            csn_q   <= csn_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        last_d  = last_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        csn_d   = csn_q;

        case (state_q)
            IDLE, WAIT: begin
                sck_d = 1'b0;
                csn_d = (state_q == IDLE);
                if (hs) begin
                    if (beat) begin
                        // MSB is driven at load so it is stable for the whole first low half
                        shreg_d = tdata_i;
                        last_d  = tlast_i;
                        mosi_d  = tdata_i[DATA_W-1];
                        csn_d   = 1'b0;
                        cnt_d   = '0;
                        bit_d   = BIT_LAST;
                        state_d = SHIFT;
                    end else if (tlast_i && state_q == WAIT) begin
                        cnt_d   = '0;
                        state_d = HOLD;
                    end
                end
            end

            SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        sck_d   = 1'b0;
                        shreg_d = shreg_q << 1;
                        if (bit_q == '0) begin
                            state_d = last_q ? HOLD : WAIT;
                        end else begin
                            bit_d  = bit_q - 1'b1;
                            mosi_d = shreg_q[DATA_W-2];
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            HOLD: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    csn_d   = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axis_spi_tx.sv
// Directed bench for axis_spi_tx with CLK_DIV=2, CS_IDLE_CYC=2, DATA_W=8.
// A negedge monitor records SPI events; each test task checks them inline.
module tb_axis_spi_tx;

    logic       clk_i = 1'b0;
    logic       rstn_i = 1'b0;
    logic [7:0] tdata_i = '0;
    logic [0:0] tkeep_i = '0;
    logic       tlast_i = 1'b0;
    logic       tvalid_i = 1'b0;
    logic       tready_o, sck_o, mosi_o, csn_o, busy_o;

    int n_checks = 0;
    int n_fail = 0;
    int hs_cyc = 0;

    axis_spi_tx #(
        .DATA_W(8),
        .CLK_DIV(2),
        .CS_IDLE_CYC(2)
    ) dut (
        .clk_i(clk_i),
        .rstn_i(rstn_i),
        .tdata_i(tdata_i),
        .tkeep_i(tkeep_i),
        .tlast_i(tlast_i),
        .tvalid_i(tvalid_i),
        .tready_o(tready_o),
        .sck_o(sck_o),
        .mosi_o(mosi_o),
        .csn_o(csn_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int          rises = 0, csn_rises = 0, low_run = 0;
    int          fall_cyc = 0, rise_cyc = 0, tr_rise_cyc = 0;
    int          rise_at [0:255];
    int          low_len [0:255];
    logic        prev_csn = 1'b1, prev_sck = 1'b0, prev_tr = 1'b0;
    logic [63:0] bits = '0;

    always @(negedge clk_i) begin
        prev_csn <= csn_o;
        prev_sck <= sck_o;
        prev_tr  <= tready_o;
        if (prev_csn && !csn_o) fall_cyc <= cyc;
        if (!prev_csn && csn_o) begin
            rise_cyc  <= cyc;
            csn_rises <= csn_rises + 1;
        end
        if (!prev_tr && tready_o) tr_rise_cyc <= cyc;
        if (sck_o) begin
            if (!prev_sck) begin
                if (rises < 256) begin
                    rise_at[rises] <= cyc;
                    low_len[rises] <= low_run;
                end
                rises <= rises + 1;
                bits  <= {bits[62:0], mosi_o};
            end
            low_run <= 0;
        end else begin
            low_run <= low_run + 1;
        end
    end

    task automatic send(input logic [7:0] d, input logic k, input logic l, output bit ok);
        tdata_i  = d;
        tkeep_i  = k;
        tlast_i  = l;
        tvalid_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk_i);
            if (tready_o) begin
                ok = 1'b1;
                hs_cyc = cyc;
            end
        end
        @(posedge clk_i);
        #1;
        tvalid_i = 1'b0;
        tkeep_i  = '0;
        tlast_i  = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk_i);
            if (tready_o) ok = 1'b1;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({csn_o, sck_o, mosi_o, tready_o, busy_o} !== 5'b10000) begin
            $display("FAIL reset_outputs: got csn,sck,mosi,tready,busy=%b required 10000",
                     {csn_o, sck_o, mosi_o, tready_o, busy_o});
            n_fail++;
        end
        #5 rstn_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (tready_o !== 1'b0) begin
            $display("FAIL reset_rdy_delay: got tready=%b required 0 before first edge", tready_o);
            n_fail++;
        end
        @(negedge clk_i);
        n_checks++;
        if (tready_o !== 1'b1) begin
            $display("FAIL reset_rdy_set: got tready=%b required 1", tready_o);
            n_fail++;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_single();
        bit ok;
        int b;
        b = rises;
        send(8'hA5, 1'b1, 1'b1, ok);
        n_checks++;
        if (!ok) begin $display("FAIL single_hs: got timeout required handshake"); n_fail++; end
        wait_ready(ok);
        n_checks++;
        if (!ok) begin $display("FAIL single_end: got timeout required tready"); n_fail++; end
        n_checks++;
        if (fall_cyc - hs_cyc !== 1) begin
            $display("FAIL single_csn_fall: got %0d required 1", fall_cyc - hs_cyc); n_fail++;
        end
        n_checks++;
        if (rise_at[b] - fall_cyc !== 2) begin
            $display("FAIL single_first_rise: got %0d required 2", rise_at[b] - fall_cyc); n_fail++;
        end
        n_checks++;
        if (rise_at[b+1] - rise_at[b] !== 4) begin
            $display("FAIL single_sck_period: got %0d required 4", rise_at[b+1] - rise_at[b]); n_fail++;
        end
        n_checks++;
        if (rises - b !== 8) begin
            $display("FAIL single_rises: got %0d required 8", rises - b); n_fail++;
        end
        n_checks++;
        if (bits[7:0] !== 8'hA5) begin
            $display("FAIL single_bits: got %h required a5", bits[7:0]); n_fail++;
        end
        n_checks++;
        if (rise_cyc - fall_cyc !== 34) begin
            $display("FAIL single_csn_low: got %0d required 34", rise_cyc - fall_cyc); n_fail++;
        end
        n_checks++;
        if (tr_rise_cyc - rise_cyc !== 2) begin
            $display("FAIL single_gap: got %0d required 2", tr_rise_cyc - rise_cyc); n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2, ok3;
        int b, cr;
        b  = rises;
        cr = csn_rises;
        send(8'h3C, 1'b1, 1'b0, ok1);
        send(8'hFF, 1'b1, 1'b1, ok2);
        wait_ready(ok3);
        n_checks++;
        if (!(ok1 && ok2 && ok3)) begin
            $display("FAIL b2b_progress: got %b%b%b required 111", ok1, ok2, ok3); n_fail++;
        end
        n_checks++;
        if (rises - b !== 16) begin
            $display("FAIL b2b_rises: got %0d required 16", rises - b); n_fail++;
        end
        n_checks++;
        if (bits[15:0] !== 16'h3CFF) begin
            $display("FAIL b2b_bits: got %h required 3cff", bits[15:0]); n_fail++;
        end
        n_checks++;
        if (csn_rises - cr !== 1) begin
            $display("FAIL b2b_csn_rises: got %0d required 1", csn_rises - cr); n_fail++;
        end
        n_checks++;
        if (low_len[b+8] !== 3 || low_len[b+7] !== 2 || low_len[b+9] !== 2) begin
            $display("FAIL b2b_low_time: got %0d,%0d,%0d required 2,3,2",
                     low_len[b+7], low_len[b+8], low_len[b+9]);
            n_fail++;
        end
    endtask

    task automatic test_wait();
        bit ok;
        int b, bad;
        b = rises;
        bad = 0;
        send(8'h81, 1'b1, 1'b0, ok);
        wait_ready(ok);
        n_checks++;
        if (!ok) begin $display("FAIL wait_enter: got timeout required tready"); n_fail++; end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            n_checks++;
            if ({csn_o, sck_o, tready_o} !== 3'b001) begin
                $display("FAIL wait_hold: got csn,sck,tready=%b required 001 at cycle %0d",
                         {csn_o, sck_o, tready_o}, i);
                n_fail++;
            end
        end
        @(posedge clk_i);
        #1;
        send(8'h7E, 1'b1, 1'b1, ok);
        wait_ready(ok);
        n_checks++;
        if (rises - b !== 16 || bits[15:0] !== 16'h817E) begin
            $display("FAIL wait_bits: got %0d rises data %h required 16 rises data 817e",
                     rises - b, bits[15:0]);
            n_fail++;
        end
    endtask

    task automatic test_null();
        bit ok;
        int b;
        b = rises;
        send(8'hFF, 1'b0, 1'b0, ok);
        n_checks++;
        if (!ok) begin $display("FAIL null_idle_hs: got timeout required handshake"); n_fail++; end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            n_checks++;
            if ({csn_o, busy_o, tready_o, sck_o} !== 4'b1010) begin
                $display("FAIL null_idle: got csn,busy,tready,sck=%b required 1010",
                         {csn_o, busy_o, tready_o, sck_o});
                n_fail++;
            end
        end
        @(posedge clk_i);
        #1;
        send(8'h55, 1'b1, 1'b0, ok);
        wait_ready(ok);
        send(8'h00, 1'b0, 1'b1, ok);
        wait_ready(ok);
        n_checks++;
        if (!ok) begin $display("FAIL null_close: got timeout required tready"); n_fail++; end
        n_checks++;
        if (rises - b !== 8 || bits[7:0] !== 8'h55) begin
            $display("FAIL null_bits: got %0d rises data %h required 8 rises data 55",
                     rises - b, bits[7:0]);
            n_fail++;
        end
        n_checks++;
        if (rise_cyc - hs_cyc !== 3) begin
            $display("FAIL null_hold: got csn rise %0d after hs required 3", rise_cyc - hs_cyc);
            n_fail++;
        end
    endtask

    task automatic test_tdata_change();
        bit ok, saw;
        int b;
        b = rises;
        saw = 1'b0;
        send(8'hC3, 1'b1, 1'b1, ok);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk_i);
            #1;
            tdata_i  = (i % 2 == 0) ? 8'h3C : 8'($urandom);
            tkeep_i  = 1'b1;
            tlast_i  = 1'b1;
            tvalid_i = 1'b1;
            @(negedge clk_i);
            if (tready_o) saw = 1'b1;
        end
        tvalid_i = 1'b0;
        tkeep_i  = '0;
        tlast_i  = 1'b0;
        n_checks++;
        if (saw) begin $display("FAIL chg_tready: got tready=1 required 0 during frame"); n_fail++; end
        wait_ready(ok);
        n_checks++;
        if (rises - b !== 8 || bits[7:0] !== 8'hC3) begin
            $display("FAIL chg_bits: got %0d rises data %h required 8 rises data c3",
                     rises - b, bits[7:0]);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        bit ok, found;
        int b;
        b = rises;
        found = 1'b0;
        send(8'hF0, 1'b1, 1'b1, ok);
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk_i);
            if (rises - b == 4) found = 1'b1;
        end
        n_checks++;
        if (!found || {sck_o, mosi_o} !== 2'b11) begin
            $display("FAIL rst_mid_pre: got found=%b sck,mosi=%b required 1 11",
                     found, {sck_o, mosi_o});
            n_fail++;
        end
        #2 rstn_i = 1'b0;
        #1;
        n_checks++;
        if ({csn_o, sck_o, mosi_o, tready_o, busy_o} !== 5'b10000) begin
            $display("FAIL rst_mid_outputs: got csn,sck,mosi,tready,busy=%b required 10000",
                     {csn_o, sck_o, mosi_o, tready_o, busy_o});
            n_fail++;
        end
        #10 rstn_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        b = rises;
        send(8'h0F, 1'b1, 1'b1, ok);
        wait_ready(ok);
        n_checks++;
        if (fall_cyc - hs_cyc !== 1) begin
            $display("FAIL rst_mid_csn_fall: got %0d required 1", fall_cyc - hs_cyc); n_fail++;
        end
        n_checks++;
        if (rises - b !== 8 || bits[7:0] !== 8'h0F) begin
            $display("FAIL rst_mid_bits: got %0d rises data %h required 8 rises data 0f",
                     rises - b, bits[7:0]);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_wait();
        test_null();
        test_tdata_change();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
